// File: rtl/stream_to_vga_fifo.sv
// Elastic pixel FIFO between the convolution stream and the VGA raster.
// Locks to stream sop, starts on a raster frame boundary, blanks on underflow.
module stream_to_vga_fifo #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 1024,
  parameter int PREFILL = 512,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     valid_in,
  input  logic                     sop_in,
  input  logic                     eop_in,
  output logic                     ready_out,
  input  logic                     visible,
  input  logic                     frame_start,
  output logic [DATA_W-1:0]        pix_out,
  output logic                     pix_valid,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     underflow,
  output logic [1:0]               state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [18:0] LAST = 19'(IMG_W * IMG_H - 1);

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_rdata;
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [CW-1:0]       r_count;
  logic [18:0]         r_rdcnt;
  logic                r_pv;
  logic                r_uflow;

  logic w_full;
  logic w_empty;
  logic w_start;
  logic w_uflow;
  logic w_rd;
  logic w_wr;
  logic w_last;
  logic w_unused;

  assign w_unused = eop_in;
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_start  = (r_state == FILL) && frame_start
                    && (r_count >= CW'(PREFILL));
  assign w_uflow  = (r_state == STREAM) && visible && w_empty;
  assign w_rd     = w_start
                    || ((r_state == STREAM) && visible && !w_empty);
  assign w_wr     = valid_in && ready_out
                    && ((r_state != SEEK) || sop_in);
  assign w_last   = w_rd && (r_rdcnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= SEEK;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      SEEK:    if (valid_in && sop_in) w_next = FILL;
      FILL:    if (w_start && !w_last) w_next = STREAM;
      STREAM:  if (w_uflow)            w_next = FLUSH;
               else if (w_last)        w_next = FILL;
      FLUSH:   w_next = SEEK;
      default: w_next = SEEK;
    endcase
  end

  always_comb begin
    ready_out = 1'b0;
    unique case (r_state)
      SEEK:    ready_out = 1'b1;
      FILL:    ready_out = !w_full;
      STREAM:  ready_out = !w_full;
      default: ready_out = 1'b0;
    endcase
  end

  // RAM kept free of reset so it maps to block memory.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= data_in;
    if (w_rd) r_rdata <= r_mem[r_rptr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_rdcnt <= '0;
      r_pv    <= 1'b0;
      r_uflow <= 1'b0;
    end else if (r_state == FLUSH) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_rdcnt <= '0;
      r_pv    <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      if (w_wr && !w_rd)      r_count <= r_count + 1'b1;
      else if (!w_wr && w_rd) r_count <= r_count - 1'b1;
      if (w_rd) r_rdcnt <= w_last ? '0 : r_rdcnt + 1'b1;
      r_pv    <= w_rd;
      r_uflow <= r_uflow | w_uflow;
    end
  end

  assign pix_out    = r_pv ? r_rdata : '0;
  assign pix_valid  = r_pv;
  assign fill_level = r_count;
  assign underflow  = r_uflow;
  assign state_dbg  = r_state;

endmodule

// File: doc/stream_to_vga_fifo.md
Name: stream_to_vga_fifo

Overview:
- Elastic buffer between the 3x3 convolution output stream (valid/ready plus sop/eop) and the VGA pixel pins, on pix_clk.
- Absorbs the convolution stage's bursty, back-pressured output and re-times it to the raster.
- Pops exactly one pixel per visible cycle, starting on a VGA frame boundary.
- On underflow it blanks, flags the error, flushes and re-locks to the next stream frame start.

Parameters:
DATA_W, 8, pixel width
DEPTH, 1024, FIFO entries (power of two)
PREFILL, 512, minimum occupancy before streaming may start at a frame boundary
IMG_W, 640, visible pixels per line
IMG_H, 480, visible lines per frame

Ports:
clk  in  1  pixel clock (pix_clk)
reset  in  1  asynchronous, active-high reset
data_in  in  DATA_W  stream pixel
valid_in  in  1  stream beat valid
sop_in  in  1  first pixel of stream frame, qualified by valid_in
eop_in  in  1  last pixel of stream frame, qualified by valid_in
ready_out  out  1  upstream ready
visible  in  1  raster active-video flag from vga_sync
frame_start  in  1  one-cycle pulse coincident with visible at hcount=0, vcount=0
pix_out  out  DATA_W  registered pixel to VGA_R/G/B
pix_valid  out  1  pix_out holds a popped pixel this cycle
fill_level  out  $clog2(DEPTH)+1  current occupancy
underflow  out  1  sticky; cleared only by reset
state_dbg  out  2  SEEK=0, FILL=1, STREAM=2, FLUSH=3

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=SEEK, FIFO empty, fill_level=0, pix_out=0, pix_valid=0, underflow=0, read count=0. Reset mid-frame discards all contents immediately.
- Accept: a beat is accepted when valid_in && ready_out.
- ready_out rules:
  - SEEK: ready_out=1. Non-sop beats are discarded.
  - FILL and STREAM: ready_out = !full. There is no write-through when full, even if a read occurs in the same cycle.
  - FLUSH: ready_out=0.
- Write: an accepted beat is written in FILL/STREAM, or in SEEK when sop_in=1. The sop beat itself is stored.
- eop_in is informational only: a sop_in accepted in FILL/STREAM is stored as normal data, with no resync.
- Read (pop): occurs only in STREAM when visible=1 and the FIFO is non-empty.
- Latency: pix_out and pix_valid are registered, so the popped pixel appears the cycle after the visible cycle (one-cycle latency; top level delays syncs by 1).
- When no pop occurs: pix_out=0, pix_valid=0.
- Occupancy: fill_level updates +1 on write, -1 on read, unchanged on simultaneous write and read. Pointers wrap modulo DEPTH. Full when fill_level==DEPTH.
- FSM:
  - SEEK -> FILL on an accepted beat with sop_in=1.
  - FILL -> STREAM on frame_start && fill_level>=PREFILL. The pop happens in that same cycle, so the frame's first pixel is not lost. If frame_start arrives with fill_level<PREFILL, stay in FILL and wait for the next frame.
  - STREAM: a 19-bit read counter increments per pop.
    - After pop number IMG_W*IMG_H (307200), counter=0 and go to FILL, keeping the contents (the next frame is already buffering).
    - visible=1 with the FIFO empty is an underflow: no pop, pix_out=0 next cycle, underflow<=1, go to FLUSH. A simultaneous write in that cycle does not prevent underflow (no bypass).
  - FLUSH: pointers and fill_level are zeroed in one cycle, read counter=0, then go to SEEK.
- frame_start outside FILL is ignored. visible during SEEK/FILL/FLUSH outputs 0 with pix_valid=0.
- Storage: inferred simple dual-port RAM with registered read.

Test Plan:
- DEPTH=16, PREFILL=8, IMG_W=4, IMG_H=2. Reset, then push 3 non-sop beats then sop beat 0x11 -> first three dropped with ready_out=1; state=FILL; fill_level=1.
- Push 0x11..0x18 (sop on 0x11), then frame_start with visible for 8 cycles -> pix_out sequence 0x11..0x18 each one cycle later; pix_valid=1 for 8 cycles; state returns to FILL after 8 pops; fill_level=0.
- Write 16 beats with visible=0 -> fill_level=16, ready_out=0; a 17th valid beat is held and not written; after one pop, ready_out=1 and the 17th beat is accepted.
- In STREAM with 2 entries, 4 visible cycles -> 2 valid pixels, then pix_out=0, underflow=1, state FLUSH then SEEK, fill_level=0; underflow stays 1 until reset.
- frame_start with fill_level=5 (<8) -> remains FILL, no pix_valid. Next frame_start with fill_level=8 -> STREAM.
- Assert reset mid-STREAM with fill_level=6 -> asynchronously fill_level=0, pix_valid=0, state_dbg=0, ready_out=1.
